// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined MIPS core.
// Handles sequential fetch, j/jal with one delay slot, EX redirects, stalls and bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus8,
  output logic        id_valid,
  output logic        jump_taken
);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic        id_is_jump;
  logic [31:0] id_pc_plus4;
  logic [31:0] jump_target;

  assign id_is_jump  = id_valid_q &&
                       ((id_instr_q[31:26] == OP_J) || (id_instr_q[31:26] == OP_JAL));
  assign id_pc_plus4 = id_pc_q + 32'd4;
  assign jump_target = {id_pc_plus4[31:28], id_instr_q[25:0], 2'b00};

  // A redirect from EX outranks a jump in ID (that jump would sit in a branch delay slot).
  assign jump_taken  = id_is_jump && !stall && !ex_redirect && !reset;

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (ex_redirect && stall) begin
      // IF/ID holds the branch delay slot, so only the PC moves.
      pc_d = ex_target;
    end else if (ex_redirect) begin
      pc_d       = ex_target;
      id_instr_d = NOP_INSTR;
      id_pc_d    = pc_q;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = id_is_jump ? jump_target : pc_q + 32'd4;
      id_instr_d = imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0000_0000;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus8 = id_pc_q + 32'd8;
  assign id_valid    = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver pushes reference-model expectations,
// a monitor pops and compares them against the DUT each cycle.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, pc, id_instr, id_pc, id_pc_plus8;
  logic        id_valid, jump_taken;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .pc(pc), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus8(id_pc_plus8),
    .id_valid(id_valid), .jump_taken(jump_taken)
  );

  // Instruction memory: a fixed hash of the address, with two planted jumps.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0000_0020: h = 32'h0C00_0010;   // jal 0x40
      32'h0000_0050: h = 32'h0800_0015;   // j 0x54
      default: begin
        h = (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5BD1_E995;
        if (a < 32'h200 && (h[31:26] == 6'b000010 || h[31:26] == 6'b000011))
          h[31:26] = 6'b001000;
      end
    endcase
    return h;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        en;
    logic        jt;
    logic [31:0] pc;
  } comb_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] idpc;
    logic [31:0] plus8;
    logic        valid;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural reference state.
  logic        m_init = 1'b0;
  logic [31:0] m_pc, m_instr, m_idpc;
  logic        m_valid;

  task automatic cycle(input logic r, input logic s, input logic x, input logic [31:0] t);
    logic [31:0] rd;
    logic        is_jump;
    comb_exp_t   ce;
    reg_exp_t    re;
    @(negedge clk);
    reset = r; stall = s; ex_redirect = x; ex_target = t;
    rd      = mem_word(m_pc);
    is_jump = m_init && m_valid && (m_instr[31:26] == 6'd2 || m_instr[31:26] == 6'd3);
    ce.en = m_init;
    ce.jt = !r && !x && !s && is_jump;
    ce.pc = m_pc;
    comb_q.push_back(ce);
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_idpc = 32'h0; m_valid = 1'b0;
      m_init = 1'b1;
    end else if (x) begin
      if (!s) begin
        m_instr = NOP_INSTR; m_idpc = m_pc; m_valid = 1'b0;
      end
      m_pc = t;
    end else if (!s) begin
      logic [31:0] dslot;
      dslot = m_idpc + 32'd4;
      m_idpc  = m_pc;
      m_pc    = is_jump ? {dslot[31:28], m_instr[25:0], 2'b00} : m_pc + 32'd4;
      m_instr = rd;
      m_valid = 1'b1;
    end
    re.pc = m_pc; re.instr = m_instr; re.idpc = m_idpc;
    re.plus8 = m_idpc + 32'd8; re.valid = m_valid;
    reg_q.push_back(re);
  endtask

  // Monitor: combinational outputs just after inputs settle, registers just after the edge.
  initial begin
    comb_exp_t ce;
    reg_exp_t  re;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        ce = comb_q.pop_front();
        if (ce.en) begin
          chk("jump_taken", {31'd0, jump_taken}, {31'd0, ce.jt});
          chk("imem_addr", imem_addr, ce.pc);
        end
      end
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        re = reg_q.pop_front();
        chk("pc", pc, re.pc);
        chk("id_instr", id_instr, re.instr);
        chk("id_pc", id_pc, re.idpc);
        chk("id_pc_plus8", id_pc_plus8, re.plus8);
        chk("id_valid", {31'd0, id_valid}, {31'd0, re.valid});
      end
    end
  end

  initial begin
    // Reset and sequential fetch from RESET_PC.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    // jal at 0x20.
    cycle(0, 0, 1, 32'h20);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    // j at 0x50.
    cycle(0, 0, 1, 32'h50);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    // Plain redirect squash.
    cycle(0, 0, 1, 32'h100);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    // Stall held three cycles with j in IF/ID.
    cycle(0, 0, 1, 32'h50);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    // Redirect during stall, then reset mid-stall.
    cycle(0, 1, 1, 32'h180);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 1, 32'h300);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    // PC wrap and misaligned target.
    cycle(0, 0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0103);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic        r, s, x;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      x = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
        2:       t = ($urandom_range(0, 1) == 0) ? 32'h20 : 32'h50;
        default: t = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      cycle(r, s, x, t);
    end
    @(posedge clk);
    #3;
    checks++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", comb_q.size() + reg_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
